// File: rtl/count_arbiter.sv
// count_arbiter: two requesters share one WIDTH-bit up-counter. A round-robin
// pointer resolves contention, each window counts from 0 up to the owner's
// latched target, and completion is flagged by a one-cycle done pulse.
// Handshake: reqN is held high for the whole window; grant marks the owner
// from the edge after the request until the completion/abort edge, and doneN
// pulses for one cycle only on a completion (never on abort or reset).
module count_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic             pause,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] counter_out,
    output logic             dbg_state
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state, w_state_nx;
    logic             r_owner, w_owner_nx;
    logic             r_ptr, w_ptr_nx;
    logic             r_cool, w_cool_nx;
    logic [WIDTH-1:0] r_target, w_target_nx;
    logic [WIDTH-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_grant, w_grant_nx;
    logic             r_done0, w_done0_nx;
    logic             r_done1, w_done1_nx;
    logic             w_pick;
    logic             w_own_req;

    // State and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_ptr    <= 1'b0;
            r_cool   <= 1'b0;
            r_target <= '0;
            r_cnt    <= '0;
            r_grant  <= 2'b00;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_ptr    <= w_ptr_nx;
            r_cool   <= w_cool_nx;
            r_target <= w_target_nx;
            r_cnt    <= w_cnt_nx;
            r_grant  <= w_grant_nx;
            r_done0  <= w_done0_nx;
            r_done1  <= w_done1_nx;
        end
    end

    // Arbitration, counting, completion and abort decisions.
    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_ptr_nx    = r_ptr;
        w_cool_nx   = 1'b0;
        w_target_nx = r_target;
        w_cnt_nx    = r_cnt;
        w_grant_nx  = r_grant;
        w_done0_nx  = 1'b0;
        w_done1_nx  = 1'b0;
        // With both requests up the pointer decides; otherwise the lone requester.
        w_pick      = (req0 && req1) ? r_ptr : req1;
        w_own_req   = r_owner ? req1 : req0;

        case (r_state)
            IDLE: begin
                // r_cool forces one quiet IDLE cycle after every window ends.
                if (!r_cool && (req0 || req1)) begin
                    w_state_nx  = RUN;
                    w_owner_nx  = w_pick;
                    w_ptr_nx    = ~w_pick;
                    w_cnt_nx    = '0;
                    w_target_nx = w_pick ? target1 : target0;
                    w_grant_nx  = w_pick ? 2'b10 : 2'b01;
                end
            end
            RUN: begin
                if (!w_own_req) begin
                    // Abort outranks completion: no done pulse.
                    w_state_nx = IDLE;
                    w_grant_nx = 2'b00;
                    w_cool_nx  = 1'b1;
                end else if (r_cnt == r_target) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 2'b00;
                    w_cool_nx  = 1'b1;
                    w_done0_nx = ~r_owner;
                    w_done1_nx = r_owner;
                end else if (!pause) begin
                    w_cnt_nx = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = 2'b00;
            end
        endcase
    end

    assign grant       = r_grant;
    assign busy        = (r_state == RUN);
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign counter_out = r_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter. The driver applies one input vector per
// cycle and queues the hand-computed output expected after that edge; a
// separate monitor pops and compares one entry after every rising edge.
module tb_count_arbiter;

    localparam int W = 4;
    localparam int EW = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] target0 = '0;
    logic [W-1:0] target1 = '0;
    logic         pause = 1'b0;
    logic [1:0]   grant;
    logic         busy;
    logic         done0;
    logic         done1;
    logic [W-1:0] counter_out;
    logic         dbg_state;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    bit            drv_done = 1'b0;

    count_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .target0(target0), .target1(target1), .pause(pause),
        .grant(grant), .busy(busy), .done0(done0), .done1(done1),
        .counter_out(counter_out), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Apply one vector before the next rising edge and queue its expectation.
    task automatic step(input logic rst, input logic q0, input logic q1,
                        input logic [W-1:0] t0, input logic [W-1:0] t1,
                        input logic p, input logic [1:0] eg,
                        input logic ed0, input logic ed1,
                        input logic [W-1:0] ec, input string nm);
        logic eb;
        @(negedge clk);
        reset = rst; req0 = q0; req1 = q1;
        target0 = t0; target1 = t1; pause = p;
        eb = (eg != 2'b00);
        exp_q.push_back({eb, eg, eb, ed0, ed1, ec});
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs 1 time unit after each rising edge.
    initial begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {dbg_state, grant, busy, done0, done1, counter_out};
                n_vec++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL %s: got state/grant/busy/d0/d1/cnt=%b required %b", nm, act, exp);
                end
            end
        end
    end

    // Driver: directed vectors
    initial begin
        // single request, target 3, target0 changes mid-window are ignored
        step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "reset");
        step(0, 1, 0, 3, 0, 0, 2'b01, 0, 0, 0, "single_e1");
        step(0, 1, 0, 7, 0, 0, 2'b01, 0, 0, 1, "single_e2");
        step(0, 1, 0, 7, 0, 0, 2'b01, 0, 0, 2, "single_e3");
        step(0, 1, 0, 7, 0, 0, 2'b01, 0, 0, 3, "single_e4");
        step(0, 1, 0, 7, 0, 0, 2'b00, 1, 0, 3, "single_done");
        step(0, 0, 0, 7, 0, 0, 2'b00, 0, 0, 3, "single_idle");

        // contention after reset: requester 0 first, one quiet cycle, then 1
        step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "reset2");
        step(0, 1, 1, 2, 2, 0, 2'b01, 0, 0, 0, "cont_e1");
        step(0, 1, 1, 2, 2, 0, 2'b01, 0, 0, 1, "cont_e2");
        step(0, 1, 1, 2, 2, 0, 2'b01, 0, 0, 2, "cont_e3");
        step(0, 1, 1, 2, 2, 0, 2'b00, 1, 0, 2, "cont_done0");
        step(0, 0, 1, 2, 2, 0, 2'b00, 0, 0, 2, "cont_gap");
        step(0, 0, 1, 2, 2, 0, 2'b10, 0, 0, 0, "cont_e6");
        step(0, 1, 1, 2, 9, 0, 2'b10, 0, 0, 1, "cont_e7");
        step(0, 1, 1, 2, 9, 0, 2'b10, 0, 0, 2, "cont_e8");
        step(0, 0, 1, 2, 9, 0, 2'b00, 0, 1, 2, "cont_done1");
        step(0, 0, 0, 2, 9, 0, 2'b00, 0, 0, 2, "cont_idle");

        // pause two cycles after grant; pause on completion edge does not block
        step(0, 0, 1, 0, 2, 0, 2'b10, 0, 0, 0, "pause_e1");
        step(0, 0, 1, 0, 2, 1, 2'b10, 0, 0, 0, "pause_e2");
        step(0, 0, 1, 0, 2, 1, 2'b10, 0, 0, 0, "pause_e3");
        step(0, 0, 1, 0, 2, 0, 2'b10, 0, 0, 1, "pause_e4");
        step(0, 0, 1, 0, 2, 0, 2'b10, 0, 0, 2, "pause_e5");
        step(0, 0, 1, 0, 2, 1, 2'b00, 0, 1, 2, "pause_done1");
        step(0, 0, 0, 0, 2, 0, 2'b00, 0, 0, 2, "pause_idle");

        // abort at count 1; pointer now favours requester 1
        step(0, 1, 0, 5, 0, 0, 2'b01, 0, 0, 0, "abort_e1");
        step(0, 1, 0, 5, 0, 0, 2'b01, 0, 0, 1, "abort_e2");
        step(0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 1, "abort_drop");
        step(0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 1, "abort_hold");

        // contention with pointer at 1, target zero windows
        step(0, 1, 1, 4, 0, 0, 2'b10, 0, 0, 0, "tz_grant1");
        step(0, 1, 1, 4, 0, 0, 2'b00, 0, 1, 0, "tz_done1");
        step(0, 1, 0, 4, 0, 0, 2'b00, 0, 0, 0, "tz_gap");
        step(0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, "tz_grant0");
        step(0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, "tz_done0");
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "tz_idle");

        // abort outranks completion on the same edge
        step(0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, "prio_grant");
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "prio_abort");
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, "prio_idle");

        // reset mid-window, then requester 0 wins contention; reset on completion edge
        step(0, 1, 0, 5, 0, 0, 2'b01, 0, 0, 0, "rst_e1");
        step(0, 1, 0, 5, 0, 0, 2'b01, 0, 0, 1, "rst_e2");
        step(0, 1, 0, 5, 0, 0, 2'b01, 0, 0, 2, "rst_e3");
        step(1, 1, 1, 5, 0, 0, 2'b00, 0, 0, 0, "rst_mid");
        step(0, 1, 1, 1, 1, 0, 2'b01, 0, 0, 0, "rst_regrant");
        step(0, 1, 1, 1, 1, 0, 2'b01, 0, 0, 1, "rst_count");
        step(1, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, "rst_on_done");
        step(0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, "rst_idle");

        repeat (3) @(negedge clk);
        drv_done = 1'b1;
    end

    // Final report, bounded by a cycle budget
    initial begin
        int cyc;
        cyc = 0;
        while (!drv_done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        n_vec++;
        if (!drv_done || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: driver_done=%0b pending=%0d required done=1 pending=0", drv_done, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
